// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads W0..W15 over a valid/ready input, expands W16..W63
// in a 16-word sliding window, and presents one word per round in a registered output slot.
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        block_start,
    input  logic [31:0] msg_word,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic        round_ready,
    output logic        w_valid,
    output logic [31:0] w_data,
    output logic [5:0]  round_idx,
    output logic        first_round,
    output logic        last_round,
    output logic        busy,
    output logic        block_done
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_e;

    localparam logic [6:0] ROUNDS_C = 7'(NUM_ROUNDS);
    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_e            state_q, state_d;
    logic [15:0][31:0] win_q, win_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [5:0]        idx_q, idx_d;
    logic              w_valid_q, w_valid_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              slot_free, push;
    logic [31:0]       push_word, expand_w, s0, s1;

    assign slot_free = !w_valid_q || round_ready;

    always_comb begin
        s0 = {win_q[1][6:0], win_q[1][31:7]} ^ {win_q[1][17:0], win_q[1][31:18]} ^ (win_q[1] >> 3);
        s1 = {win_q[14][16:0], win_q[14][31:17]} ^ {win_q[14][18:0], win_q[14][31:19]} ^ (win_q[14] >> 10);
        expand_w = s1 + win_q[9] + s0 + win_q[0];
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        w_data_d  = w_data_q;
        idx_d     = idx_q;
        w_valid_d = w_valid_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_word = '0;
        if (w_valid_q && round_ready) w_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (block_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (msg_valid && slot_free) begin
                    push      = 1'b1;
                    push_word = msg_word;
                    if (cnt_q == 7'd15) state_d = EXPAND;
                end
            end
            EXPAND: begin
                // once all rounds are produced, the only remaining event is the final handshake
                if (slot_free && (cnt_q < ROUNDS_C)) begin
                    push      = 1'b1;
                    push_word = expand_w;
                end else if (w_valid_q && round_ready && (idx_q == LAST_IDX)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            w_data_d  = push_word;
            w_valid_d = 1'b1;
            idx_d     = cnt_q[5:0];
            cnt_d     = cnt_q + 7'd1;
            win_d     = {push_word, win_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            w_data_q  <= '0;
            idx_q     <= '0;
            w_valid_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            w_data_q  <= w_data_d;
            idx_q     <= idx_d;
            w_valid_q <= w_valid_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign msg_ready   = (state_q == LOAD) && slot_free;
    assign w_valid     = w_valid_q;
    assign w_data      = w_data_q;
    assign round_idx   = idx_q;
    assign first_round = w_valid_q && (idx_q == 6'd0);
    assign last_round  = w_valid_q && (idx_q == LAST_IDX);
    assign busy        = (state_q != IDLE);
    assign block_done  = done_q;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" and zero blocks, backpressure,
// ignored/back-to-back starts and a mid-block reset, checked against a reference schedule.
module tb_sha256_msg_schedule;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        block_start = 1'b0;
    logic [31:0] msg_word = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic        round_ready = 1'b0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [5:0]  round_idx;
    logic        first_round, last_round, busy, block_done;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] msg_blk [16];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];

    typedef struct {
        int          t;
        logic [31:0] w;
    } vec_t;
    vec_t abc_tbl [8];

    sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
        .clk(clk), .reset_n(reset_n), .block_start(block_start),
        .msg_word(msg_word), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .round_ready(round_ready), .w_valid(w_valid), .w_data(w_data),
        .round_idx(round_idx), .first_round(first_round), .last_round(last_round),
        .busy(busy), .block_done(block_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic compute_ref();
        for (int t = 0; t < 16; t++) ref_w[t] = msg_blk[t];
        for (int t = 16; t < 64; t++)
            ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg_blk[i] = '0;
        msg_blk[0]  = 32'h61626380;
        msg_blk[15] = 32'h00000018;
        compute_ref();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) msg_blk[i] = '0;
        compute_ref();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_w_valid"}, 32'(w_valid), 0);
        chk({tag, "_w_data"}, w_data, 0);
        chk({tag, "_round_idx"}, 32'(round_idx), 0);
        chk({tag, "_msg_ready"}, 32'(msg_ready), 0);
        chk({tag, "_first_last"}, {30'd0, first_round, last_round}, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_block_done"}, 32'(block_done), 0);
    endtask

    // Runs one block from the current posedge+1. bp: random stalls; poke: stray starts at t=5/40;
    // abort_t >= 0: reset when word abort_t is presented; chain: start next block on block_done.
    task automatic run_block(input bit start_now, input bit bp, input bit poke,
                             input int abort_t, input bit chain);
        int mi = 0;
        int cyc = 1;
        int exp_idx = 0;
        bit stalled = 0;
        bit done_seen = 0;
        bit aborted = 0;
        logic [31:0] held = '0;
        if (start_now) begin
            block_start = 1'b1;
            @(posedge clk); #1;
            block_start = 1'b0;
        end
        while (!done_seen && !aborted && cyc < 400) begin
            msg_valid   = (mi < 16) && (!bp || $urandom_range(0, 3) != 0);
            msg_word    = msg_valid ? msg_blk[mi] : 32'hDEADBEEF;
            round_ready = !bp || ($urandom_range(0, 2) != 0);
            block_start = poke && (exp_idx == 5 || exp_idx == 40);
            @(negedge clk);
            if (!bp && cyc == 1) chk("ready_cycle1", 32'(msg_ready), 1);
            if (stalled) begin
                chk("stall_valid", 32'(w_valid), 1);
                chk("stall_hold", w_data, held);
            end
            if (abort_t >= 0 && w_valid && exp_idx == abort_t) begin
                reset_n = 1'b0;
                #1;
                check_reset_vals("mid_reset");
                msg_valid = 1'b0; round_ready = 1'b0; block_start = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(posedge clk); #1;
                aborted = 1;
            end else begin
                if (block_done) begin
                    done_seen = 1;
                    chk("done_after_last", exp_idx, 64);
                    chk("busy_at_done", 32'(busy), 0);
                    if (!bp) chk("done_cycle", cyc, 66);
                end else begin
                    chk("busy", 32'(busy), 1);
                end
                if (w_valid) begin
                    chk("round_idx", 32'(round_idx), exp_idx);
                    if (exp_idx < 64) chk($sformatf("w_data_t%0d", exp_idx), w_data, ref_w[exp_idx]);
                    chk("first_round", 32'(first_round), 32'(exp_idx == 0));
                    chk("last_round", 32'(last_round), 32'(exp_idx == 63));
                    if (!bp && exp_idx == 0) chk("first_latency", cyc, 2);
                    if (round_ready) begin
                        if (exp_idx < 64) got_w[exp_idx] = w_data;
                        exp_idx++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held = w_data;
                    end
                end else begin
                    chk("flags_idle", {30'd0, first_round, last_round}, 0);
                end
                if (msg_valid && msg_ready) mi++;
                if (done_seen && chain) block_start = 1'b1;
                @(posedge clk); #1;
                block_start = 1'b0;
                cyc++;
            end
        end
        msg_valid = 1'b0;
        round_ready = 1'b0;
        if (!aborted) chk("block_completed", 32'(done_seen), 1);
    endtask

    initial begin
        abc_tbl[0] = '{0,  32'h61626380};
        abc_tbl[1] = '{1,  32'h00000000};
        abc_tbl[2] = '{14, 32'h00000000};
        abc_tbl[3] = '{15, 32'h00000018};
        abc_tbl[4] = '{16, 32'h61626380};
        abc_tbl[5] = '{17, 32'h000F0000};
        abc_tbl[6] = '{18, 32'h7DA86405};
        abc_tbl[7] = '{19, 32'h600003C6};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        set_abc();
        for (int i = 0; i < 64; i++) got_w[i] = 32'hXXXXXXXX;
        run_block(1, 0, 0, -1, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("abc_tbl_t%0d", abc_tbl[i].t), got_w[abc_tbl[i].t], abc_tbl[i].w);

        set_zero();
        run_block(1, 0, 0, -1, 0);

        set_abc();
        run_block(1, 1, 1, -1, 1);
        run_block(0, 0, 0, -1, 0);

        run_block(1, 0, 0, 30, 0);
        for (int i = 0; i < 64; i++) got_w[i] = 32'hXXXXXXXX;
        run_block(1, 0, 0, -1, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("abc_after_reset_t%0d", abc_tbl[i].t), got_w[abc_tbl[i].t], abc_tbl[i].w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
